register_bank_16x32: RTL

Sixteen-entry, 32-bit register bank that sits directly downstream of the 4-to-16 write-address decoder in the register-bank datapath. It consumes the decoder's one-hot 16-bit enable vector, qualified by a write strobe, and stores write data into the selected register on the clock edge. It provides two registered read ports with same-cycle write bypass, a sticky flag for malformed enable vectors, and a committed-write counter for debug.

---
 rtl/register_bank_16x32.sv | 41 ++++
 1 files changed

// File: rtl/register_bank_16x32.sv
// register_bank_16x32: 16x32 register bank with one-hot write select, two bypassed registered read ports, sticky enable error and write counter
module register_bank_16x32 #(
   parameter int DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [15:0]           reg_enable,
   input  logic                  write_strobe,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic [3:0]            read_addr_a,
   input  logic [3:0]            read_addr_b,
   input  logic                  error_clear,
   output logic [DATA_WIDTH-1:0] read_data_a,
   output logic [DATA_WIDTH-1:0] read_data_b,
   output logic                  enable_error,
   output logic [15:0]           write_count
);
   logic [DATA_WIDTH-1:0] regs [16];
   logic one_hot, commit, bad;
   always_comb begin
      one_hot = (reg_enable != '0) && ((reg_enable & (reg_enable - 16'd1)) == '0);
      commit  = write_strobe && one_hot;
      bad     = write_strobe && !one_hot;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) regs[i] <= RESET_VALUE;
         read_data_a  <= RESET_VALUE;
         read_data_b  <= RESET_VALUE;
         enable_error <= 1'b0;
         write_count  <= '0;
      end else begin
         for (int i = 0; i < 16; i++) if (commit && reg_enable[i]) regs[i] <= write_data;
         read_data_a  <= (commit && reg_enable[read_addr_a]) ? write_data : regs[read_addr_a];
         read_data_b  <= (commit && reg_enable[read_addr_b]) ? write_data : regs[read_addr_b];
         enable_error <= bad ? 1'b1 : error_clear ? 1'b0 : enable_error;
         write_count  <= write_count + 16'(commit);
      end
   end
endmodule
